ram_1kx8: RTL and testbench
===========================

Name: ram_1kx8

Overview:
- Single-port synchronous RAM, 1024 x 8, used as general data/program store in the CPU datapath.
- One clock, one address bus shared by read and write, registered read data.
- After reset, a hardware sweep clears every location to zero before the array accepts accesses.

Parameters:
- DATA_W, 8, data word width in bits
- ADDR_W, 10, address width; depth = 2**ADDR_W (1024)
- INIT_VAL, 8'h00, value written to every location by the post-reset clear sweep

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst_n  input  1  asynchronous active-low reset
- we  input  1  write enable; 1 = write din to mem[addr] on this edge
- addr  input  ADDR_W  word address for read and write
- din  input  DATA_W  write data
- dout  output  DATA_W  registered read data
- init_busy  output  1  high while the post-reset clear sweep runs; accesses ignored

Behaviour:
- Reset (rst_n low, asynchronous): dout = 0, init_busy = 1, sweep counter = 0. Array contents are not touched asynchronously.
- State machine has two states, CLEAR and RUN. Reset enters CLEAR.
- CLEAR:
  - Each clock writes INIT_VAL to mem[counter], then the counter increments.
  - When the counter reaches 2**ADDR_W-1, that location is written and the state moves to RUN on the same edge.
  - The sweep lasts exactly 1024 cycles. init_busy deasserts on the edge that completes the last write.
  - we, addr and din are ignored. dout holds 0.
- RUN, write (we=1): mem[addr] <= din on the rising edge. This is write-first: dout <= din on the same edge, so the new data is visible one cycle later.
- RUN, read (we=0): dout <= mem[addr] on the rising edge. Read latency is 1 cycle. dout holds its value until the next edge.
- Back-to-back accesses to the same address:
  - A write followed by a read returns the written value with no stall.
  - Consecutive writes: the last one wins.
- Address range: all 1024 addresses are valid. There is no wrap or out-of-range case, since the address is exactly ADDR_W bits.
- Reset asserted mid-sweep or mid-operation:
  - dout clears immediately and the sweep restarts from address 0.
  - A write in progress on an edge coincident with reset assertion is discarded.
- X/unknown on we during RUN is a bench error. The design treats it as no write.

Optional Feature:
- Macro RAM_PARITY_EN.
- When defined:
  - The array stores DATA_W+1 bits per word, the extra bit being even parity of din, computed on write.
  - The CLEAR sweep writes parity of INIT_VAL.
  - An extra output par_err (1 bit) is added. It is registered alongside dout and is 1 when the stored parity does not match the parity of the stored data for the word just read.
  - par_err resets to 0 and is 0 during CLEAR.
- When undefined:
  - There is no parity bit, no par_err port, and the array is DATA_W wide.
  - Functional behaviour is otherwise identical.

Test Plan:
- Reset then idle: hold rst_n=0 for 3 cycles, release.
  - init_busy = 1 for exactly 1024 cycles, then 0.
  - dout = 0 throughout.
- Post-clear read: after init_busy falls, read addresses 0, 511, 1023 with we=0 -> dout = 8'h00 for each, 1 cycle after the address is presented.
- Write/read: write addr 0 = 8'h05, then addr 1 = 8'h15 (we=1, one cycle each), then we=0 at addr 1.
  - dout = 8'h15 one cycle later.
  - Reading addr 0 then gives 8'h05.
- Write-first: write addr 10'h3FF = 8'hA5 with we=1 -> dout = 8'hA5 on the following cycle.
- Accesses during CLEAR: pulse we=1, addr 5, din 8'hFF while init_busy = 1. After the sweep completes, reading addr 5 gives 8'h00.
- Mid-sweep reset: assert rst_n=0 after 300 sweep cycles.
  - dout = 0 immediately.
  - After release, init_busy stays high for a full 1024 cycles.
  - With RAM_PARITY_EN defined, par_err stays 0 across all reads.

Source files
------------

// File: rtl/ram_1kx8.sv
`timescale 1ns/1ps
// ram_1kx8: 1024 x 8 single-port synchronous RAM that clears itself after reset.
// Define RAM_PARITY_EN to store an even-parity bit per word and expose par_err.
module ram_1kx8 #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 10,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              init_busy
`ifdef RAM_PARITY_EN
    ,
    output logic              par_err
`endif
);

`ifdef RAM_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif
    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    function automatic logic [WORD_W-1:0] encode(input logic [DATA_W-1:0] d);
`ifdef RAM_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    typedef enum logic {CLEAR, RUN} state_t;
    // Which register currently drives dout; lets the array read stay reset-free.
    typedef enum logic [1:0] {SRC_ZERO, SRC_MEM, SRC_BYP} src_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   sweep_reg;
    src_t                src_reg;
    logic [DATA_W-1:0]   byp_reg;
    logic [WORD_W-1:0]   rd_word_reg;
    logic [WORD_W-1:0]   mem [DEPTH];

    logic                wr_en;
    logic                rd_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [WORD_W-1:0]   wr_word;

    always_comb begin
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_addr = sweep_reg;
        wr_word = encode(INIT_VAL);
        if (state_reg == CLEAR) begin
            wr_en = 1'b1;
        end else if (we) begin
            wr_en   = 1'b1;
            wr_addr = addr;
            wr_word = encode(din);
        end else begin
            rd_en = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_word_reg <= mem[addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= CLEAR;
            sweep_reg <= '0;
            src_reg   <= SRC_ZERO;
            byp_reg   <= '0;
            init_busy <= 1'b1;
        end else begin
            case (state_reg)
                CLEAR: begin
                    src_reg   <= SRC_ZERO;
                    sweep_reg <= sweep_reg + 1'b1;
                    if (sweep_reg == LAST_ADDR) begin
                        state_reg <= RUN;
                        init_busy <= 1'b0;
                    end
                end
                RUN: begin
                    if (wr_en) begin
                        src_reg <= SRC_BYP;
                        byp_reg <= din;
                    end else begin
                        src_reg <= SRC_MEM;
                    end
                end
                default: state_reg <= CLEAR;
            endcase
        end
    end

    always_comb begin
        case (src_reg)
            SRC_MEM: dout = rd_word_reg[DATA_W-1:0];
            SRC_BYP: dout = byp_reg;
            default: dout = '0;
        endcase
    end

`ifdef RAM_PARITY_EN
    assign par_err = (src_reg == SRC_MEM) &&
                     (rd_word_reg[DATA_W] != ^rd_word_reg[DATA_W-1:0]);
`endif

endmodule

// File: tb/tb_ram_1kx8.sv
`timescale 1ns/1ps
// tb_ram_1kx8: directed + randomized check of ram_1kx8 against an array model.
module tb_ram_1kx8;

    logic       clk;
    logic       rst_n;
    logic       we;
    logic [9:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       init_busy;
`ifdef RAM_PARITY_EN
    logic       par_err;
`endif

    ram_1kx8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (we),
        .addr      (addr),
        .din       (din),
        .dout      (dout),
        .init_busy (init_busy)
`ifdef RAM_PARITY_EN
        ,
        .par_err   (par_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         vecs;
    int         errs;
    logic [7:0] ref_mem [1024];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ref_clear();
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    endtask

    // One access; inputs change 1ns after a rising edge, dout checked 1ns after the next.
    task automatic access(input logic w, input logic [9:0] a, input logic [7:0] d, input string tag);
        logic [7:0] exp;
        we   = w;
        addr = a;
        din  = d;
        @(posedge clk);
        #1;
        if (w) begin
            ref_mem[a] = d;
            exp = d;
        end else begin
            exp = ref_mem[a];
        end
        check(tag, {24'h0, dout}, {24'h0, exp});
`ifdef RAM_PARITY_EN
        check({tag, "_par"}, {31'h0, par_err}, 32'h0);
`endif
        $display("%0t %s we=%0b addr=%03h din=%02h dout=%02h exp=%02h", $time, tag, w, a, d, dout, exp);
        we = 1'b0;
    endtask

    // Runs edges while init_busy is high (or until stop_at edges), with junk inputs.
    task automatic sweep(input int stop_at, output int n, output int bad);
        n   = 0;
        bad = 0;
        while (init_busy && n < 2000 && n != stop_at) begin
            if (n == 5) begin
                we   = 1'b1;
                addr = 10'd5;
                din  = 8'hFF;
            end else begin
                we   = 1'($urandom_range(0, 1));
                addr = 10'($urandom);
                din  = 8'($urandom);
            end
            @(posedge clk);
            #1;
            n++;
            if (dout !== 8'h00) bad++;
`ifdef RAM_PARITY_EN
            if (par_err !== 1'b0) bad++;
`endif
        end
        we = 1'b0;
    endtask

    initial begin
        int         n;
        int         bad;
        logic       w;
        logic [9:0] a;
        logic [7:0] d;

        vecs  = 0;
        errs  = 0;
        rst_n = 1'b0;
        we    = 1'b0;
        addr  = '0;
        din   = '0;
        ref_clear();

        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", {24'h0, dout}, 32'h0);
        check("rst_busy", {31'h0, init_busy}, 32'h1);
        rst_n = 1'b1;
        sweep(-1, n, bad);
        check("sweep_len", n, 1024);
        check("sweep_dout", bad, 0);
        check("run_busy", {31'h0, init_busy}, 32'h0);

        access(1'b0, 10'd0,   8'h00, "clr_rd0");
        access(1'b0, 10'd511, 8'h00, "clr_rd511");
        access(1'b0, 10'd1023, 8'h00, "clr_rd1023");
        access(1'b0, 10'd5,   8'h00, "clr_rd5_ignored_wr");

        access(1'b1, 10'd0, 8'h05, "wr0");
        access(1'b1, 10'd1, 8'h15, "wr1");
        access(1'b0, 10'd1, 8'h00, "rd1");
        access(1'b0, 10'd0, 8'h00, "rd0");
        access(1'b1, 10'h3FF, 8'hA5, "wr_first_3ff");
        access(1'b0, 10'h3FF, 8'h00, "rd3ff");
        access(1'b1, 10'd7, 8'h11, "wr7_a");
        access(1'b1, 10'd7, 8'h22, "wr7_b");
        access(1'b0, 10'd7, 8'h00, "rd7_last_wins");

        for (int i = 0; i < 400; i++) begin
            w = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 15));
            d = 8'($urandom);
            access(w, a, d, "rand");
        end

        // Asynchronous reset while dout holds nonzero data.
        access(1'b1, 10'h2A, 8'h5C, "wr_pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_dout", {24'h0, dout}, 32'h0);
        check("async_rst_busy", {31'h0, init_busy}, 32'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        sweep(300, n, bad);
        check("partial_sweep_len", n, 300);
        check("partial_sweep_busy", {31'h0, init_busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid_sweep_rst_dout", {24'h0, dout}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sweep(-1, n, bad);
        check("resweep_len", n, 1024);
        check("resweep_dout", bad, 0);
        ref_clear();

        access(1'b0, 10'h2A,  8'h00, "post_rst_rd2a");
        access(1'b0, 10'h3FF, 8'h00, "post_rst_rd3ff");
        access(1'b0, 10'd1,   8'h00, "post_rst_rd1");
        access(1'b1, 10'd9,   8'h3C, "post_rst_wr9");
        access(1'b0, 10'd9,   8'h00, "post_rst_rd9");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
